// File: rtl/i2c_arbiter.sv
// rtl/i2c_arbiter.sv - round-robin arbiter sharing one I2C master among NUM_REQ requesters
module i2c_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 9
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*8-1:0]            req_addr,
  input  logic [NUM_REQ*DATA_WIDTH*8-1:0] req_data,
  input  logic [NUM_REQ*8-1:0]            req_size,
  input  logic [23:0]                     timeout,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              done,
  output logic [NUM_REQ-1:0]              fail,
  output logic [7:0]                      rdata,
  output logic                            busy,
  output logic                            m_start,
  output logic [7:0]                      m_addr,
  output logic [DATA_WIDTH*8-1:0]         m_data,
  output logic [7:0]                      m_size,
  input  logic                            m_valid_trans,
  input  logic                            m_valid_recep,
  input  logic                            m_error,
  input  logic [7:0]                      m_data_received
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DW = DATA_WIDTH * 8;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_START   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] fail_q, fail_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               m_start_q, m_start_d;
  logic [7:0]         m_addr_q, m_addr_d;
  logic [DW-1:0]      m_data_q, m_data_d;
  logic [7:0]         m_size_q, m_size_d;
  logic [23:0]        wd_q, wd_d;
  logic               trans_h_q, recep_h_q, err_h_q;

  logic               win_found;
  logic [IW-1:0]      win_idx;
  int                 scan_idx;
  logic               trans_edge, recep_edge, err_edge, good_edge;

  assign trans_edge = m_valid_trans & ~trans_h_q;
  assign recep_edge = m_valid_recep & ~recep_h_q;
  assign err_edge   = m_error & ~err_h_q;
  // m_addr_q[0] is the latched rw bit: only the matching success flag completes
  assign good_edge  = m_addr_q[0] ? recep_edge : trans_edge;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = IW'(scan_idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    fail_d    = '0;
    rdata_d   = rdata_q;
    m_start_d = 1'b0;
    m_addr_d  = m_addr_q;
    m_data_d  = m_data_q;
    m_size_d  = m_size_q;
    wd_d      = wd_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          owner_d  = win_idx;
          gnt_d    = NUM_REQ'(1) << win_idx;
          m_addr_d = req_addr[int'(win_idx)*8 +: 8];
          m_data_d = req_data[int'(win_idx)*DW +: DW];
          m_size_d = req_size[int'(win_idx)*8 +: 8];
          // an empty write has nothing to send: reject without touching the bus
          if (!m_addr_d[0] && (m_size_d == 8'd0)) begin
            fail_d  = gnt_d;
            state_d = S_RELEASE;
          end else begin
            state_d = S_START;
          end
        end
      end
      S_START: begin
        m_start_d = 1'b1;
        wd_d      = timeout;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (err_edge) begin
          fail_d  = gnt_q;
          state_d = S_RELEASE;
        end else if (good_edge) begin
          done_d  = gnt_q;
          if (m_addr_q[0]) rdata_d = m_data_received;
          state_d = S_RELEASE;
        end else if (timeout != 24'd0) begin
          if (wd_q <= 24'd1) begin
            wd_d    = '0;
            fail_d  = gnt_q;
            state_d = S_RELEASE;
          end else begin
            wd_d = wd_q - 24'd1;
          end
        end
      end
      default: begin
        gnt_d   = '0;
        ptr_d   = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      fail_q    <= '0;
      rdata_q   <= '0;
      m_start_q <= 1'b0;
      m_addr_q  <= '0;
      m_data_q  <= '0;
      m_size_q  <= '0;
      wd_q      <= '0;
      trans_h_q <= 1'b0;
      recep_h_q <= 1'b0;
      err_h_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
      rdata_q   <= rdata_d;
      m_start_q <= m_start_d;
      m_addr_q  <= m_addr_d;
      m_data_q  <= m_data_d;
      m_size_q  <= m_size_d;
      wd_q      <= wd_d;
      trans_h_q <= m_valid_trans;
      recep_h_q <= m_valid_recep;
      err_h_q   <= m_error;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign fail    = fail_q;
  assign rdata   = rdata_q;
  assign busy    = (state_q != S_IDLE);
  assign m_start = m_start_q;
  assign m_addr  = m_addr_q;
  assign m_data  = m_data_q;
  assign m_size  = m_size_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb/tb_i2c_arbiter.sv - bench for i2c_arbiter against a transaction-level model
module tb_i2c_arbiter;
  localparam int N   = 4;
  localparam int DWB = 9;
  localparam int DW  = DWB * 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N*8-1:0]    req_addr = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N*8-1:0]    req_size = '0;
  logic [23:0]       timeout = '0;
  logic [N-1:0]      gnt, done, fail;
  logic [7:0]        rdata;
  logic              busy, m_start;
  logic [7:0]        m_addr;
  logic [DW-1:0]     m_data;
  logic [7:0]        m_size;
  logic              m_valid_trans = 1'b0;
  logic              m_valid_recep = 1'b0;
  logic              m_error = 1'b0;
  logic [7:0]        m_data_received = '0;

  i2c_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DWB)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .req_size(req_size), .timeout(timeout), .gnt(gnt), .done(done), .fail(fail),
    .rdata(rdata), .busy(busy), .m_start(m_start), .m_addr(m_addr), .m_data(m_data),
    .m_size(m_size), .m_valid_trans(m_valid_trans), .m_valid_recep(m_valid_recep),
    .m_error(m_error), .m_data_received(m_data_received)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // model: owner (-1 = nobody), whether start was issued, cycles waited, result pending
  int            md_own, md_ptr, md_waited;
  bit            md_started, md_report;
  bit            h_trans, h_recep, h_err;
  logic [N-1:0]  exp_gnt, exp_done, exp_fail;
  logic          exp_start;
  logic [7:0]    exp_addr, exp_size, exp_rdata;
  logic [DW-1:0] exp_data;

  int            got[$];
  logic [N-1:0]  prev_gnt;
  int            nwait, ri;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic pin(input string nm, input logic [127:0] act, input logic [127:0] mdl,
                     input logic [127:0] lit);
    chk({nm, "_dut"}, act, lit);
    chk({nm, "_model"}, mdl, lit);
  endtask

  task automatic model_reset();
    md_own = -1; md_ptr = 0; md_waited = 0; md_started = 0; md_report = 0;
    h_trans = 0; h_recep = 0; h_err = 0;
    exp_gnt = '0; exp_done = '0; exp_fail = '0; exp_start = 0;
    exp_addr = '0; exp_size = '0; exp_rdata = '0; exp_data = '0;
  endtask

  task automatic model_step();
    bit e_t, e_r, e_e;
    e_t = m_valid_trans & ~h_trans;
    e_r = m_valid_recep & ~h_recep;
    e_e = m_error & ~h_err;
    h_trans = m_valid_trans; h_recep = m_valid_recep; h_err = m_error;
    exp_done = '0; exp_fail = '0; exp_start = 0;
    if (md_report) begin
      md_ptr = (md_own + 1) % N;
      md_own = -1;
      md_report = 0;
      exp_gnt = '0;
    end else if (md_own < 0) begin
      for (int k = 0; k < N; k++)
        if (md_own < 0 && req[(md_ptr + k) % N]) md_own = (md_ptr + k) % N;
      if (md_own >= 0) begin
        exp_gnt  = N'(1 << md_own);
        exp_addr = req_addr[md_own*8 +: 8];
        exp_data = req_data[md_own*DW +: DW];
        exp_size = req_size[md_own*8 +: 8];
        md_started = 0;
        md_waited = 0;
        if (!exp_addr[0] && exp_size == 8'd0) begin
          exp_fail = exp_gnt;
          md_report = 1;
        end
      end
    end else if (!md_started) begin
      md_started = 1;
      exp_start = 1;
    end else begin
      md_waited++;
      if (e_e) begin
        exp_fail = exp_gnt; md_report = 1;
      end else if (exp_addr[0] ? e_r : e_t) begin
        exp_done = exp_gnt; md_report = 1;
        if (exp_addr[0]) exp_rdata = m_data_received;
      end else if (timeout != 0 && md_waited >= int'(timeout)) begin
        exp_fail = exp_gnt; md_report = 1;
      end
    end
  endtask

  task automatic compare();
    chk("gnt", gnt, exp_gnt);
    chk("done", done, exp_done);
    chk("fail", fail, exp_fail);
    chk("busy", busy, md_own >= 0);
    chk("m_start", m_start, exp_start);
    chk("m_addr", m_addr, exp_addr);
    chk("m_data", m_data, exp_data);
    chk("m_size", m_size, exp_size);
    chk("rdata", rdata, exp_rdata);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_reset();
    else model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] s);
    req_addr[i*8 +: 8] = a;
    req_size[i*8 +: 8] = s;
    req_data[i*DW +: DW] = DW'({$urandom(), $urandom(), $urandom()});
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m_start", m_start, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_size", m_size, 0);
    chk("rst_rdata", rdata, 0);
    model_reset();
    cycle();
    m_valid_trans = 0; m_valid_recep = 0; m_error = 0;
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // single write, success 50 cycles after start, then pointer moves to 1
    for (int i = 0; i < N; i++) set_req(i, 8'h50, 8'd3);
    req = 4'b0001;
    cycle();
    pin("w_gnt", gnt, exp_gnt, 4'b0001);
    pin("w_size", m_size, exp_size, 8'd3);
    cycle();
    pin("w_start", m_start, exp_start, 1'b1);
    cycles(49);
    m_valid_trans = 1;
    cycle();
    pin("w_done", done, exp_done, 4'b0001);
    req = 4'b0000;
    cycle();
    pin("w_gnt_clr", gnt, exp_gnt, 4'b0000);
    req = 4'b0011;
    cycle();
    pin("w_ptr_next", gnt, exp_gnt, 4'b0010);

    // all requesting: order must rotate 0,1,2,3,0
    req = 0;
    do_reset();
    timeout = 24'd3;
    for (int i = 0; i < N; i++) set_req(i, 8'h20, 8'd1);
    req = 4'b1111;
    got.delete();
    prev_gnt = '0;
    for (int c = 0; c < 80 && got.size() < 5; c++) begin
      cycle();
      if (gnt != 0 && prev_gnt == 0)
        for (int b = 0; b < N; b++) if (gnt[b]) got.push_back(b);
      prev_gnt = gnt;
    end
    chk("rr_count", got.size(), 5);
    for (int i = 0; i < got.size() && i < 5; i++)
      chk($sformatf("rr_order%0d", i), got[i], (i == 4) ? 0 : i);

    // read from requester 2, with a wrong-type flag that must be ignored
    req = 0;
    do_reset();
    timeout = 24'd0;
    set_req(2, 8'hA1, 8'd2);
    req = 4'b0100;
    cycle();
    pin("r_gnt", gnt, exp_gnt, 4'b0100);
    pin("r_addr", m_addr, exp_addr, 8'hA1);
    cycle();
    m_valid_trans = 1;
    cycles(3);
    m_data_received = 8'h5C;
    m_valid_recep = 1;
    cycle();
    pin("r_done", done, exp_done, 4'b0100);
    pin("r_rdata", rdata, exp_rdata, 8'h5C);

    // watchdog: fail exactly 100 cycles after entering WAIT
    req = 0;
    do_reset();
    timeout = 24'd100;
    set_req(0, 8'h40, 8'd2);
    req = 4'b0001;
    cycles(2);
    nwait = 0;
    for (int c = 1; c <= 150; c++) begin
      cycle();
      if (fail != 0) begin
        nwait = c;
        break;
      end
    end
    chk("wd_latency", nwait, 100);
    pin("wd_fail", fail, exp_fail, 4'b0001);

    // error coincident with success: fail wins
    req = 0;
    do_reset();
    timeout = 24'd0;
    set_req(0, 8'h40, 8'd2);
    req = 4'b0001;
    cycles(2);
    m_error = 1;
    m_valid_trans = 1;
    cycle();
    pin("co_fail", fail, exp_fail, 4'b0001);
    pin("co_done", done, exp_done, 4'b0000);

    // zero-size write, then reset during WAIT restarts arbitration at 0
    req = 0;
    do_reset();
    set_req(1, 8'h30, 8'd0);
    req = 4'b0010;
    cycle();
    pin("z_fail", fail, exp_fail, 4'b0010);
    pin("z_gnt", gnt, exp_gnt, 4'b0010);
    req = 0;
    cycle();
    pin("z_nostart", m_start, exp_start, 1'b0);
    cycle();
    set_req(1, 8'h30, 8'd2);
    set_req(3, 8'h30, 8'd2);
    req = 4'b1000;
    cycle();
    pin("z_gnt3", gnt, exp_gnt, 4'b1000);
    cycles(2);
    pin("z_busy", busy, md_own >= 0, 1'b1);
    req = 4'b1010;
    do_reset();
    cycle();
    pin("z_after_rst", gnt, exp_gnt, 4'b0010);

    // randomized segments
    for (int seg = 0; seg < 6; seg++) begin
      req = 0;
      do_reset();
      case ($urandom_range(0, 3))
        0: timeout = 24'd0;
        1: timeout = 24'd1;
        default: timeout = 24'($urandom_range(2, 30));
      endcase
      for (int c = 0; c < 500; c++) begin
        cycle();
        if ($urandom_range(0, 3) == 0) req = N'($urandom);
        if ($urandom_range(0, 2) == 0) begin
          ri = $urandom_range(0, N - 1);
          set_req(ri, 8'($urandom), 8'($urandom_range(0, 3)));
        end
        if ($urandom_range(0, 5) == 0) m_valid_trans = ~m_valid_trans;
        if ($urandom_range(0, 5) == 0) m_valid_recep = ~m_valid_recep;
        if ($urandom_range(0, 11) == 0) m_error = ~m_error;
        m_data_received = 8'($urandom);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 4, number of requesters (2..8); DATA_WIDTH, default 9, max bytes per transaction, matching the master.
REQ-002 clk  input  1  single clock, all logic on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req  input  NUM_REQ  per-requester transaction request, level.
REQ-005 req_addr  input  NUM_REQ*8  per-requester slave address byte; bit0 = rw (1 = read).
REQ-006 req_data  input  NUM_REQ*DATA_WIDTH*8  per-requester payload; byte 0 = register address.
REQ-007 req_size  input  NUM_REQ*8  per-requester byte count.
REQ-008 timeout  input  24  watchdog limit in clk cycles; 0 disables the watchdog.
REQ-009 gnt  output  NUM_REQ  one-hot owner of the master; all zero when idle.
REQ-010 done  output  NUM_REQ  one-cycle success pulse to the owner.
REQ-011 fail  output  NUM_REQ  one-cycle failure pulse to the owner.
REQ-012 rdata  output  8  last received byte; valid with a done pulse on a read.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 m_start  output  1  start strobe to the master.
REQ-015 m_addr  output  8  address to the master.
REQ-016 m_data  output  DATA_WIDTH*8  payload to the master.
REQ-017 m_size  output  8  byte count to the master.
REQ-018 m_valid_trans, m_valid_recep, m_error  input  1 each  master status flags.
REQ-019 m_data_received  input  8  master receive byte.

Function
REQ-020 The FSM SHALL have states IDLE, START, WAIT, RELEASE.
REQ-021 Arbitration SHALL be round-robin: search starts at pointer ptr and wraps modulo NUM_REQ; the first index with req=1 wins.
REQ-022 In IDLE with any req=1, the block SHALL, on the same edge, latch the winner index, set gnt, register m_addr/m_data/m_size from the winner's slice, and go to START.
REQ-023 A write (addr bit0 = 0) with req_size = 0 SHALL go IDLE->RELEASE with fail set and no m_start pulse.
REQ-024 START SHALL assert m_start for exactly one cycle, load the watchdog with timeout, and go to WAIT.
REQ-025 m_addr/m_data/m_size SHALL hold constant from grant through RELEASE; requester input changes after grant SHALL be ignored.
REQ-026 Master flags SHALL be rising-edge detected against a registered copy; only edges seen in WAIT count.
REQ-027 In WAIT, the completion rules SHALL be:
- m_error edge -> fail.
- For a write, m_valid_trans edge -> done.
- For a read, m_valid_recep edge -> done, and rdata captures m_data_received.
REQ-028 If the error edge and the success edge coincide in one cycle, fail SHALL win and done SHALL NOT pulse.
REQ-029 In WAIT with timeout != 0, the watchdog SHALL decrement each cycle; reaching 0 before completion SHALL cause fail.
REQ-030 A wrong-type success edge (valid_trans on a read, or valid_recep on a write) SHALL be ignored.
REQ-031 RELEASE SHALL last one cycle and:
- pulse done or fail for the owner;
- clear gnt;
- set ptr = (owner + 1) mod NUM_REQ;
- go to IDLE.
REQ-032 req deassertion during START/WAIT SHALL NOT abort; the transaction completes and is reported.
REQ-033 Minimum spacing SHALL be one IDLE cycle between consecutive grants; grant latency from req in IDLE SHALL be 1 cycle, and m_start SHALL follow 1 cycle later.
REQ-034 done and fail SHALL never be high together, and at most one bit of each SHALL be set.

Reset
REQ-035 rst low SHALL asynchronously force:
- state IDLE, ptr 0;
- gnt, done, fail, busy, m_start = 0;
- m_addr, m_data, m_size, rdata = 0;
- the watchdog and the flag-history registers = 0.
REQ-036 Reset mid-transaction SHALL drop gnt immediately with no done/fail pulse; after release, arbitration restarts at index 0.

Verification
REQ-037 req=4'b0001, write, size 3; m_valid_trans rises 50 cycles after m_start -> gnt=0001, one m_start pulse, m_size=3, done[0] pulse, gnt cleared, ptr=1.
REQ-038 req=4'b1111 held -> grants in order 0,1,2,3,0, each separated by at least one IDLE cycle.
REQ-039 Read from req 2 (addr=8'hA1); m_valid_recep rises with m_data_received=8'h5C -> done[2] pulse, rdata=8'h5C.
REQ-040 timeout=100 and no master flag -> fail pulse exactly 100 cycles after entering WAIT; an m_error edge coincident with m_valid_trans -> fail only.
REQ-041 Write request with size 0 -> fail pulse, no m_start; rst low during WAIT -> all outputs 0 asynchronously, and the next grant goes to the lowest pending index.
